fx3_gpif_reader: RTL and testbench

- Synthesizable model of the FX3 GPIF read side: the consumer end of the FPGA-to-FX3 16-bit streaming interface.
- Watches dataAvailable, drives readData in fixed-length bursts and captures the bus after the pipeline latency.
- In test mode, checks captured words against the incrementing test pattern and counts mismatches.
- Used on-chip for loopback/self-test and as the bench-side reader for the buffer and fx3StateMachine path; runs on the 60 MHz FX3 clock.

---
 rtl/fx3_gpif_reader_if.sv | 28 ++
 rtl/fx3_gpif_reader.sv | 123 ++++++++++++
 tb/tb_fx3_gpif_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fx3_gpif_reader_if.sv
// Handshake and data bus between the FX3 GPIF read-side consumer (master) and its data source (slave).
interface fx3_gpif_reader_if;
  logic        enable;
  logic        checkEnable;
  logic        dataAvailable;
  logic        bufferError;
  logic [15:0] dataIn;
  logic        readData;
  logic        wordValid;
  logic [15:0] dataOut;
  logic        burstDone;
  logic [15:0] burstCount;
  logic [15:0] mismatchCount;
  logic        overflowSeen;
  logic        busy;

  modport master (
    input  enable, checkEnable, dataAvailable, bufferError, dataIn,
    output readData, wordValid, dataOut, burstDone, burstCount,
           mismatchCount, overflowSeen, busy
  );

  modport slave (
    output enable, checkEnable, dataAvailable, bufferError, dataIn,
    input  readData, wordValid, dataOut, burstDone, burstCount,
           mismatchCount, overflowSeen, busy
  );
endinterface

// File: rtl/fx3_gpif_reader.sv
// FX3 GPIF read side: issues fixed-length readData bursts, captures the bus after a
// configurable latency and optionally checks the words against an incrementing pattern.
//
// state | meaning
// IDLE  | waiting for enable && dataAvailable
// READ  | readData high, BURST_WORDS cycles
// DRAIN | readData low, waiting for the last in-flight word
// GAP   | GAP_CYCLES idle cycles before re-arming
module fx3_gpif_reader #(
  parameter int BURST_WORDS   = 8192,
  parameter int READ_LATENCY  = 2,
  parameter int GAP_CYCLES    = 4,
  parameter int PATTERN_WIDTH = 10
) (
  input logic            clock,
  input logic            reset,
  fx3_gpif_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} state_t;

  localparam int BW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [BW-1:0] BURST_M1 = BW'(BURST_WORDS - 1);
  localparam logic [7:0]    GAP_M1   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t state, state_nxt;
  logic [BW-1:0] burst_cnt;
  logic [7:0]    gap_cnt;
  logic          read_data, last_read, cap, cap_last;

  logic [15:0] data_hold, burst_count, mismatch_count;
  logic        burst_done, overflow_seen, seed_valid;
  logic [PATTERN_WIDTH-1:0] seed, pat_v, pat_exp;

  assign read_data = (state == READ);
  assign last_read = read_data && (burst_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable && bus.dataAvailable) state_nxt = READ;
      READ:    if (burst_cnt == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = DRAIN;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Last capture ends the burst; with zero latency this happens while still in READ.
    if (cap_last) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state != READ)        burst_cnt <= BURST_M1;
      else if (burst_cnt != '0) burst_cnt <= burst_cnt - 1'b1;
      if (state != GAP)         gap_cnt <= GAP_M1;
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Each delay stage carries {last word of burst, word strobe}.
  generate
    if (READ_LATENCY == 0) begin : g_no_lat
      assign cap      = read_data;
      assign cap_last = last_read;
    end else begin : g_lat
      logic [1:0] line [READ_LATENCY];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < READ_LATENCY; i++) line[i] <= 2'b00;
        end else begin
          line[0] <= {last_read, read_data};
          for (int i = 1; i < READ_LATENCY; i++) line[i] <= line[i-1];
        end
      end
      assign cap      = line[READ_LATENCY-1][0];
      assign cap_last = line[READ_LATENCY-1][1];
    end
  endgenerate

  assign pat_v   = bus.dataIn[PATTERN_WIDTH-1:0];
  assign pat_exp = seed + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_hold      <= '0;
      burst_done     <= 1'b0;
      burst_count    <= '0;
      mismatch_count <= '0;
      overflow_seen  <= 1'b0;
      seed           <= '0;
      seed_valid     <= 1'b0;
    end else begin
      burst_done <= cap_last;
      if (cap_last) burst_count <= burst_count + 16'd1;
      if (cap) data_hold <= bus.dataIn;
      if (bus.bufferError) overflow_seen <= 1'b1;
      if (!bus.checkEnable) begin
        seed_valid <= 1'b0;
      end else if (cap) begin
        seed       <= pat_v;
        seed_valid <= 1'b1;
        if (seed_valid && (pat_v != pat_exp) && (mismatch_count != 16'hFFFF))
          mismatch_count <= mismatch_count + 16'd1;
      end
    end
  end

  // The word on the bus is presented during its capture cycle and held afterwards.
  assign bus.readData      = read_data;
  assign bus.wordValid     = cap;
  assign bus.dataOut       = cap ? bus.dataIn : data_hold;
  assign bus.burstDone     = burst_done;
  assign bus.burstCount    = burst_count;
  assign bus.mismatchCount = mismatch_count;
  assign bus.overflowSeen  = overflow_seen;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_fx3_gpif_reader.sv
// Directed bench for fx3_gpif_reader: per-cycle vector table after reset, then burst-level sequences.
module tb_fx3_gpif_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fx3_gpif_reader_if b1 ();
  fx3_gpif_reader_if b2 ();

  fx3_gpif_reader #(.BURST_WORDS(8), .READ_LATENCY(2), .GAP_CYCLES(4), .PATTERN_WIDTH(10))
    dut1 (.clock(clock), .reset(reset), .bus(b1));

  fx3_gpif_reader #(.BURST_WORDS(1), .READ_LATENCY(0), .GAP_CYCLES(0), .PATTERN_WIDTH(10))
    dut2 (.clock(clock), .reset(reset), .bus(b2));

  always #8 clock = ~clock;

  typedef struct {
    logic [15:0] din;
    logic        rd, wv, bd, busy;
    logic [15:0] dout, bc;
  } vec_t;

  vec_t tbl [17];
  logic [15:0] words [8];

  function automatic vec_t mk(input logic [15:0] din, input logic rd, input logic wv,
                              input logic bd, input logic busy, input logic [15:0] dout,
                              input logic [15:0] bc);
    vec_t v;
    v.din = din; v.rd = rd; v.wv = wv; v.bd = bd; v.busy = busy; v.dout = dout; v.bc = bc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    b1.enable = 0; b1.checkEnable = 0; b1.dataAvailable = 0; b1.bufferError = 0; b1.dataIn = '0;
    b2.enable = 0; b2.checkEnable = 0; b2.dataAvailable = 0; b2.bufferError = 0; b2.dataIn = '0;
  endtask

  task automatic do_reset(input bit check_state);
    reset = 1;
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clock);
    if (check_state) begin
      check("rst_rd",   b1.readData, 0);
      check("rst_wv",   b1.wordValid, 0);
      check("rst_dout", b1.dataOut, 0);
      check("rst_bd",   b1.burstDone, 0);
      check("rst_bc",   b1.burstCount, 0);
      check("rst_mc",   b1.mismatchCount, 0);
      check("rst_ov",   b1.overflowSeen, 0);
      check("rst_busy", b1.busy, 0);
      check("rst2_rd",  b2.readData, 0);
      check("rst2_bc",  b2.burstCount, 0);
    end
    reset = 0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < 8; i++) words[i] = 16'((base + i) % 1024);
  endtask

  // One burst on dut1 starting from IDLE; words[] is presented in the capture window (cycles 3..10).
  task automatic run_burst(input string tag, input logic chk_en, input bit avail_hold,
                           input int en_drop, input int berr_at, input logic [15:0] exp_bc,
                           input logic [15:0] exp_mc, input logic exp_ov);
    int n_rd, n_wv, n_bd;
    logic [15:0] dout_first;
    n_rd = 0; n_wv = 0; n_bd = 0; dout_first = '0;
    for (int k = 0; k < 21; k++) begin
      next_cycle();
      b1.enable        = (k < en_drop);
      b1.dataAvailable = avail_hold || (k == 0);
      b1.checkEnable   = chk_en;
      b1.bufferError   = (k == berr_at);
      b1.dataIn        = (k >= 3 && k <= 10) ? words[k-3] : 16'h0;
      @(negedge clock);
      n_rd += int'(b1.readData);
      n_wv += int'(b1.wordValid);
      n_bd += int'(b1.burstDone);
      if (k == 3) dout_first = b1.dataOut;
    end
    check({tag, "_rd_cycles"}, n_rd, 8);
    check({tag, "_wv_cycles"}, n_wv, 8);
    check({tag, "_bd_pulses"}, n_bd, 1);
    check({tag, "_dout_first"}, dout_first, words[0]);
    check({tag, "_dout_hold"}, b1.dataOut, words[7]);
    check({tag, "_bc"}, b1.burstCount, exp_bc);
    check({tag, "_mc"}, b1.mismatchCount, exp_mc);
    check({tag, "_ov"}, b1.overflowSeen, exp_ov);
  endtask

  initial begin
    int cnt_rd, cnt_busy;

    tbl[0]  = mk(100, 0, 0, 0, 0,   0, 0);
    tbl[1]  = mk(101, 1, 0, 0, 1,   0, 0);
    tbl[2]  = mk(102, 1, 0, 0, 1,   0, 0);
    tbl[3]  = mk(103, 1, 1, 0, 1, 103, 0);
    tbl[4]  = mk(104, 1, 1, 0, 1, 104, 0);
    tbl[5]  = mk(105, 1, 1, 0, 1, 105, 0);
    tbl[6]  = mk(106, 1, 1, 0, 1, 106, 0);
    tbl[7]  = mk(107, 1, 1, 0, 1, 107, 0);
    tbl[8]  = mk(108, 1, 1, 0, 1, 108, 0);
    tbl[9]  = mk(109, 0, 1, 0, 1, 109, 0);
    tbl[10] = mk(110, 0, 1, 0, 1, 110, 0);
    tbl[11] = mk(111, 0, 0, 1, 1, 110, 1);
    tbl[12] = mk(112, 0, 0, 0, 1, 110, 1);
    tbl[13] = mk(113, 0, 0, 0, 1, 110, 1);
    tbl[14] = mk(114, 0, 0, 0, 1, 110, 1);
    tbl[15] = mk(115, 0, 0, 0, 0, 110, 1);
    tbl[16] = mk(116, 1, 0, 0, 1, 110, 1);

    idle_inputs();
    do_reset(1);

    // Cycle-accurate first burst with enable and dataAvailable held high.
    for (int k = 0; k < 17; k++) begin
      next_cycle();
      b1.enable = 1; b1.dataAvailable = 1; b1.checkEnable = 1; b1.bufferError = 0;
      b1.dataIn = tbl[k].din;
      @(negedge clock);
      check($sformatf("tbl%0d_rd", k),   b1.readData,      tbl[k].rd);
      check($sformatf("tbl%0d_wv", k),   b1.wordValid,     tbl[k].wv);
      check($sformatf("tbl%0d_bd", k),   b1.burstDone,     tbl[k].bd);
      check($sformatf("tbl%0d_busy", k), b1.busy,          tbl[k].busy);
      check($sformatf("tbl%0d_dout", k), b1.dataOut,       tbl[k].dout);
      check($sformatf("tbl%0d_bc", k),   b1.burstCount,    tbl[k].bc);
      check($sformatf("tbl%0d_mc", k),   b1.mismatchCount, 16'd0);
    end

    // No data available: no burst.
    do_reset(0);
    cnt_rd = 0; cnt_busy = 0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      b1.enable = 1; b1.dataAvailable = 0; b1.checkEnable = 1;
      @(negedge clock);
      cnt_rd   += int'(b1.readData);
      cnt_busy += int'(b1.busy);
    end
    check("noavail_rd_cycles", cnt_rd, 0);
    check("noavail_busy_cycles", cnt_busy, 0);

    // Wrap-around pattern with a one-cycle dataAvailable pulse.
    fill(1020);
    run_burst("wrap", 1, 0, 99, -1, 16'd1, 16'd0, 0);

    // Corrupted word: two mismatches, then resync.
    do_reset(0);
    fill(1020);
    words[2] = 16'd500;
    run_burst("corrupt", 1, 0, 99, -1, 16'd1, 16'd2, 0);
    fill(4);
    run_burst("resync", 1, 0, 99, -1, 16'd2, 16'd2, 0);
    fill(900);
    words[3] = 16'd17;
    run_burst("chkoff", 0, 0, 99, -1, 16'd3, 16'd2, 0);
    fill(700);
    run_burst("reseed", 1, 0, 99, -1, 16'd4, 16'd2, 0);

    // Enable dropped mid-burst with dataAvailable held: burst completes, no restart.
    fill(708);
    run_burst("endrop", 1, 1, 4, -1, 16'd5, 16'd2, 0);

    // Overflow pulse during GAP, sticky across further bursts.
    fill(716);
    run_burst("ovf", 1, 0, 99, 12, 16'd6, 16'd2, 1);
    for (int b = 0; b < 3; b++) begin
      fill(724 + 8 * b);
      run_burst($sformatf("ovf_hold%0d", b), 1, 0, 99, -1, 16'(7 + b), 16'd2, 1);
    end

    // Reset asserted during word 3 of a burst.
    fill(40);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      b1.enable = 1; b1.dataAvailable = (k == 0); b1.checkEnable = 1; b1.bufferError = 0;
      b1.dataIn = (k >= 3) ? words[k-3] : 16'h0;
      reset = (k == 3);
      @(negedge clock);
      if (k == 3) check("midrst_wv_before", b1.wordValid, 1);
    end
    check("midrst_rd",   b1.readData, 0);
    check("midrst_wv",   b1.wordValid, 0);
    check("midrst_dout", b1.dataOut, 0);
    check("midrst_bc",   b1.burstCount, 0);
    check("midrst_mc",   b1.mismatchCount, 0);
    check("midrst_ov",   b1.overflowSeen, 0);
    check("midrst_busy", b1.busy, 0);
    fill(50);
    run_burst("after_rst", 1, 0, 99, -1, 16'd1, 16'd0, 0);

    // Single-word bursts, zero latency and zero gap.
    do_reset(0);
    for (int k = 0; k < 12; k++) begin
      logic rd_e;
      next_cycle();
      b2.enable = 1; b2.dataAvailable = 1; b2.checkEnable = 1; b2.bufferError = 0;
      b2.dataIn = 16'(300 + k / 2);
      @(negedge clock);
      rd_e = (k % 2 == 1);
      check($sformatf("edge%0d_rd", k),   b2.readData,   rd_e);
      check($sformatf("edge%0d_wv", k),   b2.wordValid,  rd_e);
      check($sformatf("edge%0d_bd", k),   b2.burstDone,  (k >= 2) && (k % 2 == 0));
      check($sformatf("edge%0d_bc", k),   b2.burstCount, 16'(k / 2));
      check($sformatf("edge%0d_busy", k), b2.busy,       rd_e);
      if (rd_e) check($sformatf("edge%0d_dout", k), b2.dataOut, 16'(300 + k / 2));
    end
    check("edge_mc", b2.mismatchCount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
